rr_arbiter: RTL
===============

Name: rr_arbiter

Overview:
- Parametrised N-way round-robin arbiter with enable and a registered one-hot grant.
- Successor to the fixed-priority 4-bit selector. Reset priority matches highest-index-wins, so the first arbitration is identical to the fixed-priority behaviour.
- Priority then rotates so every requester is served fairly.
- Sits in front of shared resources: CDB, memory port, functional-unit issue slots.

Parameters:
- N, 4, number of requesters; legal range N >= 2.
- IDX_W, $clog2(N), localparam; width of the pointer and the binary grant index.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- req  input  N  request vector; bit i is requester i.
- en  input  1  arbitration enable.
- gnt  output  N  registered one-hot grant; all-zero when nothing is granted.
- gnt_valid  output  1  registered; high iff gnt != 0.
- gnt_idx  output  IDX_W  registered binary index of the granted bit; 0 when gnt_valid = 0.

Behaviour:
- State:
  - ptr (IDX_W bits): the highest-priority index.
  - Output registers gnt, gnt_valid, gnt_idx.
- Reset: sampled on the clock edge while reset_n = 0. Result: gnt = 0, gnt_valid = 0, gnt_idx = 0, ptr = N-1. Reset overrides all other inputs, including mid-grant or mid-lock.
- Search order, combinational from ptr: ptr, ptr-1, ..., 0, N-1, ..., ptr+1 (descending, wrap modulo N). The winner is the first index with req = 1.
- Latency: 1 cycle. req/en sampled at edge k appear on gnt after edge k.
- Each edge, if en = 1 and req != 0:
  - gnt <= onehot(winner); gnt_idx <= winner; gnt_valid <= 1.
  - ptr <= (winner - 1) mod N, so the winner becomes lowest priority. winner = 0 wraps ptr to N-1.
- Each edge, if en = 0 or req == 0: gnt <= 0, gnt_valid <= 0, gnt_idx <= 0, ptr unchanged.
- Single requester: that requester is granted every cycle it requests. ptr still updates.
- gnt is always one-hot or zero; never more than one bit set.
- Non-power-of-2 N: the pointer decrement wraps to N-1, never to 2^IDX_W - 1. Indices >= N are never produced.
- No combinational path from req to gnt.

Optional Feature:
- Macro: RR_ARB_LOCK_EN (burst lock).
- Defined:
  - If gnt[i] = 1 and, at the next edge, en = 1 and req[i] = 1, the grant is held: gnt, gnt_idx and gnt_valid unchanged, ptr unchanged.
  - Other requesters are ignored while held.
  - When req[i] = 0 or en = 0, normal arbitration resumes that edge, using the ptr set when i was first granted.
- Not defined: re-arbitration every cycle as described above. Lock logic is absent from the netlist.

Test Plan:
- Reset: reset_n = 0 for 2 cycles with req = 4'b1111, en = 1 -> gnt = 0, gnt_valid = 0, gnt_idx = 0, ptr = 3. Release -> first gnt = 4'b1000, gnt_idx = 3.
- Full rotation (N = 4, no lock): req = 4'b1111, en = 1 held from reset -> gnt = 1000, 0100, 0010, 0001, 1000 on consecutive cycles.
- Sparse requests: req = 4'b0101 held from reset -> gnt = 0100, 0001, 0100, 0001; gnt_idx = 2, 0, 2, 0.
- Enable gating: req = 4'b1111, gnt = 1000 granted, then en = 0 for 1 cycle -> gnt = 0, gnt_valid = 0. en = 1 again -> gnt = 0100 (ptr was not advanced while disabled).
- Lock (RR_ARB_LOCK_EN defined): req = 4'b1010 from reset -> gnt = 1000 held for 3 cycles while req[3] = 1. Drop req[3] -> next gnt = 0010. Same stimulus without the macro -> 1000, 0010, 1000 alternating.
- Reset mid-operation plus N = 5: with N = 5, req = 5'b00001 -> gnt = 00001, ptr wraps to 4, not 7. Assert reset_n = 0 while gnt = 00001 -> next edge gnt = 0, ptr = 4.

Source files
------------

// File: rtl/rr_arbiter_if.sv
// rtl/rr_arbiter_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface rr_arbiter_if #(
   parameter int N = 4
) ();
   localparam int IDX_W = $clog2(N);

   logic [N-1:0]     req;
   logic             en;
   logic [N-1:0]     gnt;
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_idx;

   modport master (output req, en, input gnt, gnt_valid, gnt_idx);
   modport slave  (input req, en, output gnt, gnt_valid, gnt_idx);
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin arbiter, registered one-hot grant
// Optional burst lock enabled by defining RR_ARB_LOCK_EN.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   rr_arbiter_if.slave  bus
);
   localparam int IDX_W = $clog2(N);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] scan;
   logic             win_found;
   logic [IDX_W-1:0] ptr_next;
   logic             hold;

   // Walk downward from ptr, wrapping to N-1 (not 2^IDX_W-1), first requester wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan      = ptr;
      for (int k = 0; k < N; k++) begin
         if (!win_found && bus.req[scan]) begin
            win_found = 1'b1;
            win_idx   = scan;
         end
         scan = (scan == '0) ? LAST : scan - IDX_W'(1);
      end
   end

   assign ptr_next = (win_idx == '0) ? LAST : win_idx - IDX_W'(1);

`ifdef RR_ARB_LOCK_EN
   // Current grantee keeps the resource while it continues to request.
   assign hold = bus.en && bus.gnt_valid && ((bus.gnt & bus.req) != '0);
`else
   assign hold = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ptr           <= LAST;
         bus.gnt       <= '0;
         bus.gnt_valid <= 1'b0;
         bus.gnt_idx   <= '0;
      end else if (hold) begin
         ptr           <= ptr;
         bus.gnt       <= bus.gnt;
         bus.gnt_valid <= bus.gnt_valid;
         bus.gnt_idx   <= bus.gnt_idx;
      end else if (bus.en && win_found) begin
         ptr           <= ptr_next;
         bus.gnt       <= N'(1) << win_idx;
         bus.gnt_valid <= 1'b1;
         bus.gnt_idx   <= win_idx;
      end else begin
         ptr           <= ptr;
         bus.gnt       <= '0;
         bus.gnt_valid <= 1'b0;
         bus.gnt_idx   <= '0;
      end
   end
endmodule
